controlador_vga_param: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller. It generates VGA timing from generic porch and sync parameters and fetches framebuffer pixels over a fixed-latency read port. It supports power-of-two pixel replication (scaling) and gates display start to frame boundaries. All pixel and sync outputs are pipeline-aligned, so memory latency never skews the image. It sits between the data memory/framebuffer and the DAC pins.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/controlador_vga_param.sv | 170 +++++++++++++++++
 tb/tb_controlador_vga_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the parametrised VGA controller.
// No logic of its own; sizes counters and names the FSM states.
// Sync polarity is folded in by helper function, not by callers.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } vga_state_t;

  // Electrical levels of a sync pin.
  localparam logic SYNC_LVL_HIGH = 1'b1;
  localparam logic SYNC_LVL_LOW  = 1'b0;

  // Bit positions inside the pipelined control bundle.
  localparam int unsigned B_HS  = 4;
  localparam int unsigned B_VS  = 3;
  localparam int unsigned B_VIS = 2;
  localparam int unsigned B_RUN = 1;
  localparam int unsigned B_FS  = 0;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sy, input int unsigned bp);
    return act + fp + sy + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sy, input int unsigned bp);
    return act + fp + sy + bp;
  endfunction

  // Width able to hold every value 0..n inclusive (n itself is used as a compare bound).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Pin level for a logically active/inactive sync, honouring polarity.
  function automatic logic sync_level(input logic active, input logic neg);
    return (active ^ neg) ? SYNC_LVL_HIGH : SYNC_LVL_LOW;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register aligning control bits with memory read data.
// Latency: DEPTH clocks from din to dout.
// No backpressure: shifts every clock.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 5,
  parameter int unsigned       DEPTH   = 3,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next stage contents: new sample enters stage 0, everything else moves up one.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers clear to the inactive/blank level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/controlador_vga_param.sv
// Parametrised VGA timing generator with framebuffer fetch and pixel replication.
// Latency: address/rd_en 1 clock after the counters; pins MEM_LAT+1 clocks after.
// No backpressure: the read port is fixed-latency and always answers.
module controlador_vga_param
  import vga_pkg::*;
#(
  parameter int unsigned      H_ACTIVE   = 640,
  parameter int unsigned      H_FP       = 16,
  parameter int unsigned      H_SYNC     = 96,
  parameter int unsigned      H_BP       = 48,
  parameter int unsigned      V_ACTIVE   = 480,
  parameter int unsigned      V_FP       = 10,
  parameter int unsigned      V_SYNC     = 2,
  parameter int unsigned      V_BP       = 33,
  parameter bit               SYNC_NEG   = 1'b1,
  parameter int unsigned      SCALE_LOG2 = 0,
  parameter int unsigned      MEM_LAT    = 2,
  parameter int unsigned      ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       rd_data,
  output logic [ADDR_W-1:0] address,
  output logic              rd_en,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              n_blank,
  output logic              frame_start
);

  localparam int unsigned H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW    = cnt_width(H_TOT);
  localparam int unsigned VW    = cnt_width(V_TOT);
  localparam int unsigned DLY   = MEM_LAT + 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  // Low v_cnt bits that must be zero for a new source row to begin.
  localparam logic [VW-1:0] V_SUB_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
  localparam logic SYNC_IDLE = SYNC_NEG ? SYNC_LVL_HIGH : SYNC_LVL_LOW;
  localparam logic [4:0] DLY_RST = {SYNC_IDLE, SYNC_IDLE, 3'b000};

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  vga_state_t        state_q, state_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              rd_en_q, rd_en_d;

  logic h_wrap, v_last, at_origin, at_end;
  logic visible, hs_act, vs_act, run_nxt;
  logic [4:0] dly_in, dly_out;

  // Raster counters (free-running out of reset) and region decode.
  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    v_last    = (v_cnt_q == V_LAST);
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    at_end    = h_wrap && v_last;
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d   = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end
    visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_act  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_act  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  end

  // Display FSM: start only takes effect on frame boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!start)         state_d = IDLE;
        else if (at_origin) state_d = RUN;
      end
      RUN:        if (!start && at_end) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Fetch strobe and incremental address; row base steps once per source row.
  always_comb begin
    run_nxt   = (state_d == RUN);
    rd_en_d   = run_nxt && visible;
    address_d = address_q;
    if (rd_en_d) begin
      address_d = row_base_q + ADDR_W'(h_cnt_q >> SCALE_LOG2);
    end
    row_base_d = row_base_q;
    if (h_wrap) begin
      if (v_cnt_d == '0) begin
        row_base_d = BASE_ADDR;
      end else if ((v_cnt_d & V_SUB_MASK) == '0) begin
        row_base_d = row_base_q + ROW_STEP;
      end
    end
  end

  // State, counter and fetch registers.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      state_q    <= IDLE;
      row_base_q <= BASE_ADDR;
      address_q  <= BASE_ADDR;
      rd_en_q    <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      state_q    <= state_d;
      row_base_q <= row_base_d;
      address_q  <= address_d;
      rd_en_q    <= rd_en_d;
    end
  end

  // Control bits travel alongside the read so they meet rd_data at the pins.
  always_comb begin
    dly_in        = '0;
    dly_in[B_HS]  = sync_level(hs_act, SYNC_NEG);
    dly_in[B_VS]  = sync_level(vs_act, SYNC_NEG);
    dly_in[B_VIS] = visible;
    dly_in[B_RUN] = run_nxt;
    dly_in[B_FS]  = at_origin && run_nxt;
  end

  vga_delay_line #(
    .WIDTH   (5),
    .DEPTH   (DLY),
    .RST_VAL (DLY_RST)
  ) u_dly (
    .clk   (clock_25),
    .rst_n (reset),
    .din   (dly_in),
    .dout  (dly_out)
  );

  // Pixel gate: memory data only reaches the DAC inside a displayed visible region.
  always_comb begin
    {red, green, blue} = '0;
    if (dly_out[B_VIS] && dly_out[B_RUN]) begin
      {red, green, blue} = rd_data;
    end
  end

  assign address     = address_q;
  assign rd_en       = rd_en_q;
  assign hsync       = dly_out[B_HS];
  assign vsync       = dly_out[B_VS];
  assign n_blank     = dly_out[B_VIS];
  assign frame_start = dly_out[B_FS];

endmodule

// File: tb/tb_controlador_vga_param.sv
// Self-checking bench: small raster, 2x scaling, 3-clock memory, wrapping base address.
// Reference model derives every pin from the cycle count since reset release.
// Frame display decisions are made per frame from the start level history.
module tb_controlador_vga_param;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int SC = 1, ML = 3, AW = 32;
  localparam bit SN = 1'b1;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FR = HT * VT;             // 240
  localparam int L  = ML + 1;              // 4

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] rnd_data = '0;
  logic [23:0] rd_data;
  logic [31:0] address;
  logic        rd_en, hsync, vsync, n_blank, frame_start;
  logic [7:0]  red, green, blue;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  int pcount;

  controlador_vga_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_NEG(SN), .SCALE_LOG2(SC), .MEM_LAT(ML), .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .clock_25(clk), .reset(rst_n), .start(start), .rd_data(rd_data),
    .address(address), .rd_en(rd_en), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .n_blank(n_blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer model: returns the low 24 bits of the address it was given ML clocks ago.
  logic [23:0] mem_pipe [ML];
  initial for (int i = 0; i < ML; i++) mem_pipe[i] = '0;
  always @(posedge clk) begin
    mem_pipe[0] <= address[23:0];
    for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign rd_data = rst_n ? mem_pipe[ML-1] : rnd_data;

  // Clocks since reset release, as seen just after each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcount <= 0;
    else        pcount <= pcount + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (k=%0d)", nm, act, exp, k);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_address"}, address, BASE);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, "_n_blank"}, 32'(n_blank), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_hsync"}, 32'(hsync), 32'(SN));
    check({tag, "_vsync"}, 32'(vsync), 32'(SN));
  endtask

  typedef struct packed {
    logic        vis, hs, vs, fs, on;
    logic [31:0] addr;
  } ent_t;

  ent_t        hist [8];
  bit          disp, start_prev;
  logic [31:0] exp_addr;

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin : cmp_p
    int   h, v;
    ent_t e, d, p;
    if (!rst_n) begin
      k = 0; disp = 1'b0; start_prev = 1'b0; exp_addr = BASE;
      check_reset_pins("reset");
    end else begin
      h = k % HT;
      v = (k / HT) % VT;
      // A frame is shown only if start was high on the last clock of the previous
      // frame and either that frame was shown or start is still high now.
      if (h == 0 && v == 0) disp = (k != 0) && start_prev && (disp || start);
      e.vis  = (h < HA) && (v < VA);
      e.hs   = (h >= HA + HF) && (h < HA + HF + HS);
      e.vs   = (v >= VA + VF) && (v < VA + VF + VS);
      e.fs   = (h == 0) && (v == 0) && disp;
      e.on   = e.vis && disp;
      e.addr = BASE + 32'((v >> SC) * (HA >> SC) + (h >> SC));
      hist[k % 8] = e;
      p = (k >= 1) ? hist[(k - 1) % 8] : '0;
      if (p.on) exp_addr = p.addr;
      check("rd_en", 32'(rd_en), 32'(p.on));
      check("address", address, exp_addr);
      d = (k >= L) ? hist[(k - L) % 8] : '0;
      check("hsync", 32'(hsync), 32'(d.hs ^ SN));
      check("vsync", 32'(vsync), 32'(d.vs ^ SN));
      check("n_blank", 32'(n_blank), 32'(d.vis));
      check("frame_start", 32'(frame_start), 32'(d.fs));
      check("rgb", 32'({red, green, blue}), d.on ? {8'h0, d.addr[23:0]} : 32'd0);
      start_prev = start;
      k++;
    end
  end

  // Advance to the first clock at which the raster counter sits at 'pos' within a frame.
  task automatic wait_pos(input int pos);
    for (int i = 0; i < 2 * FR; i++) begin
      @(posedge clk); #3;
      if (pcount % FR == pos) break;
    end
    check("pos_reached", 32'(pcount % FR), 32'(pos));
  endtask

  task automatic random_phase(input int segs);
    for (int s = 0; s < segs; s++) begin
      repeat ($urandom_range(1, 400)) @(posedge clk);
      #3;
      start = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin : stim
    int first, width, idx;
    #1 rst_n = 1'b0;
    // Reset held with random inputs.
    repeat (6) begin
      @(posedge clk); #3;
      start    = ($urandom_range(0, 1) == 1);
      rnd_data = 24'($urandom);
    end

    // Release with start high from reset.
    @(posedge clk); #3;
    start = 1'b1; rst_n = 1'b1;
    first = -1; idx = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); idx++;
      if (hsync == 1'b0) begin first = idx; break; end
    end
    check("first_hsync_clk", 32'(first), 32'(HA + HF + L));
    width = 0;
    for (int i = 0; i < 100; i++) begin
      if (hsync == 1'b0) width++; else break;
      @(negedge clk); idx++;
    end
    check("hsync_width", 32'(width), 32'(HS));
    first = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); idx++;
      if (frame_start == 1'b1) begin first = idx; break; end
    end
    check("first_frame_start_clk", 32'(first), 32'(FR + L));
    check("first_pixel_rgb", 32'({red, green, blue}), 32'h00FF_FFF8);
    check("first_pixel_n_blank", 32'(n_blank), 32'd1);
    while (idx < 2 * FR - 1) begin @(negedge clk); idx++; end
    check("last_address_of_frame", address, 32'h0000_000F);

    // start raised mid-frame, then dropped mid-frame.
    @(posedge clk); #3; start = 1'b0;
    repeat (2 * FR) @(posedge clk);
    wait_pos(HT * 4 + 10);
    start = 1'b1;
    repeat (2 * FR) @(posedge clk);
    wait_pos(HT * 4 + 10);
    start = 1'b0;
    repeat (2 * FR) @(posedge clk);

    random_phase(12);

    // Reset pulsed in the middle of a displayed frame.
    @(posedge clk); #3; start = 1'b1;
    repeat (2 * FR) @(posedge clk);
    wait_pos(HT * 4 + 10);
    check("pre_reset_rgb", 32'({red, green, blue}), 32'h0000_000B);
    check("pre_reset_address", address, 32'h0000_000C);
    rst_n = 1'b0;
    #1 check_reset_pins("async_reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    first = -1; idx = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); idx++;
      if (frame_start == 1'b1) begin first = idx; break; end
    end
    check("restart_frame_start_clk", 32'(first), 32'(FR + L));

    random_phase(12);
    repeat (FR) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
